// File: rtl/doorlock_lockout.sv
// Keypad door lock: PIN entry/check, guarded PIN change, failure lockout.
// Latency: star at edge N -> compare in cycle N+1 -> open/alarm in cycle N+2.
// No backpressure: keys are one-cycle pulses; keys arriving in non-entry states are dropped.
module doorlock_lockout #(
  parameter int MAX_LEN     = 6,
  parameter int MIN_LEN     = 2,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          star,
  input  logic                          sharp,
  input  logic [9:0]                    number,
  output logic                          open,
  output logic                          alarm,
  output logic                          locked,
  output logic                          mode_active,
  output logic                          mode_set,
  output logic                          set_ok,
  output logic                          set_err,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

  localparam int CW = $clog2(MAX_LEN + 2);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, ENTRY, CHECK, OPEN, ALARM, LOCK,
    V_ENTRY, V_CHECK, NEW_ENTRY, CONFIRM, COMMIT, SET_ERR
  } state_t;

  typedef logic [MAX_LEN-1:0][3:0] pin_buf_t;

  state_t        state_q, state_d;
  pin_buf_t      ent_q, ent_d, new_q, new_d, pin_q, pin_d;
  logic [CW-1:0] cnt_q, cnt_d, new_len_q, new_len_d, pin_len_q, pin_len_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lock_q, lock_d;

  logic          dig_vld;
  logic [3:0]    dig_dat;
  logic          key_sharp, key_star, key_dig;
  logic          ovf, pin_ok, len_ok, cfm_ok, store;

  // Compare the first len digits of two buffers
  function automatic logic buf_match(input pin_buf_t a, input pin_buf_t b,
                                     input logic [CW-1:0] len);
    logic m;
    m = 1'b1;
    for (int i = 0; i < MAX_LEN; i++)
      if (i < int'(len) && a[i] != b[i]) m = 1'b0;
    return m;
  endfunction

  // Key decode: exactly one-hot digit only; sharp beats star beats digit
  always_comb begin
    dig_vld = (number != 10'd0) && ((number & (number - 10'd1)) == 10'd0);
    dig_dat = 4'd0;
    for (int k = 0; k < 10; k++)
      if (number[k]) dig_dat = 4'(k);
    key_sharp = sharp;
    key_star  = star && !sharp;
    key_dig   = dig_vld && !star && !sharp;
  end

  assign ovf    = cnt_q > CW'(MAX_LEN);
  assign pin_ok = !ovf && (cnt_q == pin_len_q) && buf_match(ent_q, pin_q, pin_len_q);
  assign len_ok = !ovf && (cnt_q >= CW'(MIN_LEN));
  assign cfm_ok = !ovf && (cnt_q == new_len_q) && buf_match(ent_q, new_q, new_len_q);

  // Next-state, buffer, counter and stored-PIN logic
  always_comb begin
    state_d   = state_q;
    ent_d     = ent_q;
    new_d     = new_q;
    cnt_d     = cnt_q;
    new_len_d = new_len_q;
    pin_d     = pin_q;
    pin_len_d = pin_len_q;
    fail_d    = fail_q;
    lock_d    = lock_q;
    store     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_sharp)    state_d = V_ENTRY;
        else if (key_dig) begin state_d = ENTRY; store = 1'b1; end
      end
      ENTRY: begin
        if (key_sharp)     state_d = IDLE;
        else if (key_star) state_d = CHECK;
        else if (key_dig)  store = 1'b1;
      end
      V_ENTRY: begin
        if (key_sharp)     state_d = IDLE;
        else if (key_star) state_d = V_CHECK;
        else if (key_dig)  store = 1'b1;
      end
      NEW_ENTRY: begin
        if (key_sharp) state_d = IDLE;
        else if (key_star) begin
          if (len_ok) begin
            state_d   = CONFIRM;
            new_len_d = cnt_q;
            cnt_d     = '0;
            ent_d     = '0;
          end else begin
            state_d = SET_ERR;
          end
        end else if (key_dig) store = 1'b1;
      end
      CONFIRM: begin
        if (key_sharp)     state_d = IDLE;
        else if (key_star) state_d = cfm_ok ? COMMIT : SET_ERR;
        else if (key_dig)  store = 1'b1;
      end
      CHECK, V_CHECK: begin
        if (pin_ok) begin
          fail_d = '0;
          if (state_q == CHECK) begin
            state_d = OPEN;
          end else begin
            state_d = NEW_ENTRY;
            cnt_d   = '0;
            ent_d   = '0;
          end
        end else begin
          // Count is bumped on entry so it is visible alongside the alarm pulse
          state_d = ALARM;
          fail_d  = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);
        end
      end
      ALARM: begin
        if (fail_q == FW'(MAX_FAIL)) begin
          state_d = LOCK;
          lock_d  = LW'(LOCK_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (lock_q == '0) begin
          state_d = IDLE;
          fail_d  = '0;
        end else begin
          lock_d = lock_q - LW'(1);
        end
      end
      COMMIT: begin
        pin_d     = new_q;
        pin_len_d = new_len_q;
        state_d   = IDLE;
      end
      OPEN, SET_ERR: state_d = IDLE;
      default:       state_d = IDLE;
    endcase

    // Digits land in the new-PIN buffer while setting, else the entry buffer
    if (store) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (CW'(i) == cnt_q) begin
          if (state_q == NEW_ENTRY) new_d[i] = dig_dat;
          else                      ent_d[i] = dig_dat;
        end
      end
      if (cnt_q <= CW'(MAX_LEN)) cnt_d = cnt_q + CW'(1);
    end

    if (state_d == IDLE) begin
      ent_d     = '0;
      new_d     = '0;
      cnt_d     = '0;
      new_len_d = '0;
    end
  end

  // State registers; reset restores the default all-zero PIN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      ent_q     <= '0;
      new_q     <= '0;
      cnt_q     <= '0;
      new_len_q <= '0;
      pin_q     <= '0;
      pin_len_q <= CW'(MIN_LEN);
      fail_q    <= '0;
      lock_q    <= '0;
    end else begin
      state_q   <= state_d;
      ent_q     <= ent_d;
      new_q     <= new_d;
      cnt_q     <= cnt_d;
      new_len_q <= new_len_d;
      pin_q     <= pin_d;
      pin_len_q <= pin_len_d;
      fail_q    <= fail_d;
      lock_q    <= lock_d;
    end
  end

  // Moore output decodes of the registered state
  always_comb begin
    open        = (state_q == OPEN);
    alarm       = (state_q == ALARM);
    locked      = (state_q == LOCK);
    set_ok      = (state_q == COMMIT);
    set_err     = (state_q == SET_ERR);
    mode_set    = (state_q == V_ENTRY) || (state_q == V_CHECK) || (state_q == NEW_ENTRY) ||
                  (state_q == CONFIRM) || (state_q == COMMIT)  || (state_q == SET_ERR);
    mode_active = !mode_set && (state_q != LOCK);
    fail_cnt    = fail_q;
  end

endmodule

// File: tb/tb_doorlock_lockout.sv
// Bench for doorlock_lockout: directed scenarios plus randomized key scripts.
// Each key is one pulse followed by a fixed quiet gap; outputs sampled on the falling edge.
// Expected values come from a queue-based model of PIN entry, change and lockout.
module tb_doorlock_lockout;
  localparam int MAX_LEN = 6, MIN_LEN = 2, MAX_FAIL = 3, LOCK_CYCLES = 16, GAP = 4;

  logic       clk = 1'b0, n_rst = 1'b0, star = 1'b0, sharp = 1'b0;
  logic [9:0] number = '0;
  logic       open, alarm, locked, mode_active, mode_set, set_ok, set_err;
  logic [1:0] fail_cnt;

  doorlock_lockout #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .MAX_FAIL(MAX_FAIL),
                     .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clk(clk), .n_rst(n_rst), .star(star), .sharp(sharp), .number(number),
    .open(open), .alarm(alarm), .locked(locked), .mode_active(mode_active),
    .mode_set(mode_set), .set_ok(set_ok), .set_err(set_err), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // model: 0 normal, 1 verifying old PIN, 2 entering new PIN, 3 confirming
  int pin[$], ent[$], nw[$];
  int mode, fails, obs;
  int lock_lo, lock_hi, open_at, alarm_at, ok_at, err_at, alarm_fc;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
  endtask

  function automatic bit same(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit in_lock(input int t);
    return (t >= lock_lo) && (t <= lock_hi);
  endfunction

  task automatic fail_event(input int base);
    fails++;
    alarm_at = base + 2;
    alarm_fc = fails;
    if (fails == MAX_FAIL) begin
      lock_lo = base + 3;
      lock_hi = base + 2 + LOCK_CYCLES;
      fails   = 0;
    end
  endtask

  task automatic model_key(input bit k_star, input bit k_sharp, input logic [9:0] k_num, input int base);
    int d;
    if (in_lock(base)) return;
    if (k_sharp) begin
      if (mode == 0 && ent.size() == 0) mode = 1;
      else mode = 0;
      ent.delete();
    end else if (k_star) begin
      case (mode)
        0: if (ent.size() != 0) begin
             if (same(ent, pin)) begin open_at = base + 2; fails = 0; end
             else fail_event(base);
             ent.delete();
           end
        1: begin
             if (same(ent, pin)) begin fails = 0; mode = 2; end
             else begin fail_event(base); mode = 0; end
             ent.delete();
           end
        2: begin
             if (ent.size() >= MIN_LEN && ent.size() <= MAX_LEN) begin nw = ent; mode = 3; end
             else begin err_at = base + 1; mode = 0; end
             ent.delete();
           end
        default: begin
             if (same(ent, nw)) begin pin = nw; ok_at = base + 1; end
             else err_at = base + 1;
             mode = 0;
             ent.delete();
           end
      endcase
    end else if ($countones(k_num) == 1) begin
      d = 0;
      for (int k = 0; k < 10; k++) if (k_num[k]) d = k;
      ent.push_back(d);
    end
  endtask

  task automatic step(input bit k_star, input bit k_sharp, input logic [9:0] k_num);
    int base;
    base = obs;
    model_key(k_star, k_sharp, k_num, base);
    star = k_star; sharp = k_sharp; number = k_num;
    @(posedge clk);
    #1;
    star = 1'b0; sharp = 1'b0; number = '0;
    for (int j = 1; j <= GAP; j++) begin
      @(negedge clk);
      obs++;
      check("open",    int'(open),    int'(obs == open_at));
      check("alarm",   int'(alarm),   int'(obs == alarm_at));
      check("set_ok",  int'(set_ok),  int'(obs == ok_at));
      check("set_err", int'(set_err), int'(obs == err_at));
      check("locked",  int'(locked),  int'(in_lock(obs)));
      if (obs == alarm_at) check("alarm_fail_cnt", int'(fail_cnt), alarm_fc);
      if (j == GAP) begin
        check("mode_set",    int'(mode_set),    in_lock(obs) ? 0 : int'(mode != 0));
        check("mode_active", int'(mode_active), in_lock(obs) ? 0 : int'(mode == 0));
        check("fail_cnt",    int'(fail_cnt),    in_lock(obs) ? MAX_FAIL : fails);
      end
    end
  endtask

  task automatic press(input int d);
    logic [9:0] v;
    v = 10'd1 << d;
    step(1'b0, 1'b0, v);
  endtask

  task automatic enter(input int q[$]);
    foreach (q[i]) press(q[i]);
  endtask

  task automatic hit_star();  step(1'b1, 1'b0, 10'd0); endtask
  task automatic hit_sharp(); step(1'b0, 1'b1, 10'd0); endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("rst_open",        int'(open),        0);
    check("rst_alarm",       int'(alarm),       0);
    check("rst_locked",      int'(locked),      0);
    check("rst_mode_active", int'(mode_active), 1);
    check("rst_mode_set",    int'(mode_set),    0);
    check("rst_set_ok",      int'(set_ok),      0);
    check("rst_set_err",     int'(set_err),     0);
    check("rst_fail_cnt",    int'(fail_cnt),    0);
    pin = '{0, 0}; ent.delete(); nw.delete();
    mode = 0; fails = 0;
    lock_lo = 1; lock_hi = 0;
    open_at = -1; alarm_at = -1; ok_at = -1; err_at = -1; alarm_fc = 0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    int q[$], c[$];
    logic [9:0] v;
    obs = 0;
    do_reset();

    // default PIN, then a too-long attempt
    enter('{0, 0}); hit_star();
    enter('{0, 0, 0}); hit_star();
    enter('{0, 0}); hit_star();

    // lockout; keys during the lock window must be ignored
    repeat (3) begin enter('{5, 5}); hit_star(); end
    press(0); press(0); hit_star(); hit_sharp(); press(0);
    enter('{0, 0}); hit_star();

    // PIN change to 1234
    hit_sharp(); enter('{0, 0}); hit_star();
    enter('{1, 2, 3, 4}); hit_star(); enter('{1, 2, 3, 4}); hit_star();
    enter('{1, 2, 3, 4}); hit_star();
    enter('{0, 0}); hit_star();

    // rejected changes from the default PIN
    do_reset();
    hit_sharp(); enter('{0, 0}); hit_star(); enter('{1, 2, 3, 4}); hit_star();
    enter('{1, 2, 3, 5}); hit_star();
    hit_sharp(); enter('{0, 0}); hit_star(); press(7); hit_star();
    hit_sharp(); enter('{0, 0}); hit_star(); enter('{1, 2, 3, 4, 5, 6, 7}); hit_star();
    enter('{0, 0}); hit_star();
    hit_sharp(); enter('{9, 9}); hit_star();
    enter('{0, 0}); hit_star();

    // key conflicts
    press(0); step(1'b0, 1'b0, 10'h003); press(0); hit_star();
    enter('{0, 0}); v = 10'd1 << 5; step(1'b1, 1'b0, v);
    press(1); hit_sharp();
    enter('{1, 2, 3, 4, 5, 6, 7}); hit_star();

    // reset in the middle of a lockout
    repeat (2) begin enter('{8}); hit_star(); end
    enter('{8}); hit_star(); hit_star(); press(3);
    do_reset();
    enter('{0, 0}); hit_star();

    // randomized key scripts
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 3))
        0: begin q = pin; enter(q); hit_star(); end
        1: begin
             q.delete();
             repeat ($urandom_range(1, 8)) q.push_back($urandom_range(0, 9));
             enter(q); hit_star();
           end
        2: begin
             hit_sharp();
             q = pin;
             if ($urandom_range(0, 3) == 0) q[0] = (q[0] + 1) % 10;
             enter(q); hit_star();
             q.delete();
             repeat ($urandom_range(1, 7)) q.push_back($urandom_range(0, 9));
             enter(q); hit_star();
             c = q;
             if ($urandom_range(0, 3) == 0) c.push_back($urandom_range(0, 9));
             enter(c); hit_star();
           end
        default: begin
             int kind, a, b;
             kind = $urandom_range(0, 6);
             a = $urandom_range(0, 9);
             b = (a + 1 + $urandom_range(0, 8)) % 10;
             case (kind)
               0: press(a);
               1: hit_star();
               2: hit_sharp();
               3: begin v = (10'd1 << a) | (10'd1 << b); step(1'b0, 1'b0, v); end
               4: begin v = 10'd1 << a; step(1'b1, 1'b0, v); end
               5: step(1'b1, 1'b1, 10'd0);
               default: step(1'b0, 1'b0, 10'd0);
             endcase
           end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
